// File: rtl/fp_mul_seq.sv
// fp_mul_seq: parametrised bit-serial floating-point multiplier with valid/ready handshake
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   of,
    output logic                   uf,
    output logic                   nv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int PW = 2 * M;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(M);
    localparam logic signed [EW-1:0] BIAS  = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] E_MAX = EW'(2 ** EXP_W - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [MAN_W-1:0] Q_FRAC   = MAN_W'(1) << (MAN_W - 1);

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [M-1:0]         ma_q;
    logic [M-1:0]         man_q;
    logic [PW-1:0]        prod_q;
    logic signed [EW-1:0] e_q;
    logic                 sign_q, rnd_q, g_q, s_q;
    logic                 in_ready_q, out_valid_q, of_q, uf_q, nv_q;
    logic [W-1:0]         result_q;

    // operand decode at accept; subnormals count as zero
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 za, zb, ia, ib, na, nb, sign_in, nv_d, special_d;
    logic [W-1:0]         special_res_d;
    logic signed [EW-1:0] e_in_d;

    assign ea        = a[W-2:MAN_W];
    assign eb        = b[W-2:MAN_W];
    assign fa        = a[MAN_W-1:0];
    assign fb        = b[MAN_W-1:0];
    assign za        = ea == '0;
    assign zb        = eb == '0;
    assign ia        = (ea == EXP_ONES) && (fa == '0);
    assign ib        = (eb == EXP_ONES) && (fb == '0);
    assign na        = (ea == EXP_ONES) && (fa != '0);
    assign nb        = (eb == EXP_ONES) && (fb != '0);
    assign sign_in   = a[W-1] ^ b[W-1];
    assign nv_d      = na | nb | (za & ib) | (ia & zb);
    assign special_d = na | nb | ia | ib | za | zb;
    assign special_res_d = nv_d      ? {1'b0, EXP_ONES, Q_FRAC} :
                           (ia | ib) ? {sign_in, EXP_ONES, {MAN_W{1'b0}}} :
                                       {sign_in, {(W-1){1'b0}}};
    assign e_in_d = {2'b00, ea} + {2'b00, eb} - BIAS;

    // one shift-add step: the multiplier sits in the low half and shifts out as the product shifts in
    logic [M:0]    sum_d;
    logic [PW-1:0] prod_d;

    assign sum_d  = {1'b0, prod_q[PW-1:M]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    assign prod_d = {sum_d, prod_q[M-1:1]};

    // normalisation of the [1,4) product to M bits plus guard and sticky
    logic         msb_n, g_n, s_n;
    logic [M-1:0] man_n;

    assign msb_n = prod_q[PW-1];
    assign man_n = msb_n ? prod_q[PW-1:M] : prod_q[PW-2:M-1];
    assign g_n   = msb_n ? prod_q[M-1] : prod_q[M-2];
    assign s_n   = msb_n ? |prod_q[M-2:0] : |prod_q[M-3:0];

    // rounding, carry renormalisation and range checks
    logic                 inc_r, of_r, uf_r;
    logic [M:0]           man_r;
    logic [MAN_W-1:0]     frac_r;
    logic signed [EW-1:0] e_r;
    logic [W-1:0]         res_r;

    assign inc_r  = rnd_q & g_q & (s_q | man_q[0]);
    assign man_r  = {1'b0, man_q} + {{M{1'b0}}, inc_r};
    assign frac_r = man_r[M] ? man_r[M-1:1] : man_r[MAN_W-1:0];
    assign e_r    = e_q + {{(EW-1){1'b0}}, man_r[M]};
    assign of_r   = e_r >= E_MAX;
    assign uf_r   = e_r[EW-1] | (e_r == '0);
    assign res_r  = of_r ? {sign_q, EXP_ONES, {MAN_W{1'b0}}} :
                    uf_r ? {sign_q, {(W-1){1'b0}}} :
                           {sign_q, e_r[EXP_W-1:0], frac_r};

    // control FSM with registered handshake, result and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            man_q       <= '0;
            prod_q      <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            rnd_q       <= 1'b0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            of_q        <= 1'b0;
            uf_q        <= 1'b0;
            nv_q        <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= sign_in;
                        rnd_q      <= rnd_mode;
                        ma_q       <= {1'b1, fa};
                        prod_q     <= {{M{1'b0}}, 1'b1, fb};
                        e_q        <= e_in_d;
                        cnt_q      <= '0;
                        of_q       <= 1'b0;
                        uf_q       <= 1'b0;
                        nv_q       <= special_d & nv_d;
                        if (special_d) begin
                            result_q <= special_res_d;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= MUL;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(MAN_W)) state_q <= NORM;
                end
                NORM: begin
                    man_q   <= man_n;
                    g_q     <= g_n;
                    s_q     <= s_n;
                    e_q     <= e_q + {{(EW-1){1'b0}}, msb_n};
                    state_q <= ROUND;
                end
                ROUND: begin
                    result_q <= res_r;
                    of_q     <= of_r;
                    uf_q     <= ~of_r & uf_r;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign of        = of_q;
    assign uf        = uf_q;
    assign nv        = nv_q;
endmodule
